mul32_seq_ctrl: RTL and testbench
=================================

# mul32_seq_ctrl

Sequential controller for the RV32M multiply path: one `multiplier_16` instance is time-shared over four 16x16 partial products to form a 64-bit product. It executes MUL, MULH, MULHSU and MULHU. It sits in the muldiv unit between the execute-stage operand mux and the writeback mux, and trades latency for area against a full 32x32 array.

## Interface
- Parameters: none.
- `clk_i` input 1: single clock; all state updates on the rising edge.
- `reset_i` input 1: synchronous, active-low reset.
- `start_i` input 1: request; accepted only in IDLE.
- `op_i` input 2: operation, sampled with `start_i`.
  - 00 = MUL (low 32 bits).
  - 01 = MULH (signed x signed, high 32 bits).
  - 10 = MULHSU (signed rs1 x unsigned rs2, high 32 bits).
  - 11 = MULHU (unsigned x unsigned, high 32 bits).
- `rs1_i` input 32: multiplicand, sampled with `start_i`.
- `rs2_i` input 32: multiplier, sampled with `start_i`.
- `kill_i` input 1: flush; aborts an in-flight operation.
- `busy_o` output 1: operation in progress.
- `done_o` output 1: one-cycle pulse; `result_o` is valid.
- `result_o` output 32: result, held until the next accepted start.

## Operation
- States: IDLE, STEP (2-bit counter `cnt` 0..3), FIX.
- **Accept** (IDLE and `start_i`=1):
  - Latch `op`.
  - Latch sign flags: `s1` = rs1[31] for MULH and MULHSU; `s2` = rs2[31] for MULH only; both 0 otherwise.
  - Latch magnitudes `a` = s1 ? -rs1 : rs1 and `b` = s2 ? -rs2 : rs2, as 32-bit unsigned. 0x8000_0000 negates to 0x8000_0000, which is the correct magnitude 2^31.
  - Clear the 64-bit accumulator `acc`; go to STEP with `cnt`=0.
- **STEP**: the 16x16 multiplier inputs are muxed by `cnt`; each step adds its product to `acc`, then `cnt` increments.
  - cnt 0: a[15:0] x b[15:0], added with shift 0.
  - cnt 1: a[15:0] x b[31:16], added << 16.
  - cnt 2: a[31:16] x b[15:0], added << 16.
  - cnt 3: a[31:16] x b[31:16], added << 32; then go to FIX.
- Accumulator width is 64 bits; no step can overflow it, since the unsigned product is < 2^64.
- **FIX**:
  - `p` = (s1 ^ s2) ? -acc : acc, 64-bit two's complement.
  - `result_o` <= (op==MUL) ? p[31:0] : p[63:32].
  - Assert `done_o`; go to IDLE.
  - A zero product with the negate flag set yields 0 (-0 = 0).
- **Start while busy**: `start_i` in STEP or FIX is ignored; there is no queueing.
- **`kill_i`**: in STEP or FIX, go to IDLE next edge. No `done_o`, and `result_o` is unchanged. `kill_i` takes priority over FIX completion. `kill_i` in IDLE has no effect; `kill_i` and `start_i` together in IDLE means start is ignored.
- **Reset** (`reset_i`=0 at an edge, any state):
  - State goes to IDLE, `cnt`=0.
  - `busy_o`=0, `done_o`=0, `result_o`=0x0000_0000; `acc` and operand registers are cleared.
  - Reset mid-operation discards the operation; no `done_o`.

## Timing
- Edge E0: start accepted.
- Edges E1..E4: the four STEP accumulations.
- Edge E5: FIX registers the result.
- `done_o`=1 and `result_o` valid in the cycle following E5; fixed latency is 5 cycles from the accepting edge.
- `busy_o`=1 from after E0 through the cycle ending at E5. It is 0 in the `done_o` cycle, so a new `start_i` can be accepted at E6 (back-to-back throughput: one op per 6 cycles).
- `done_o` is high exactly one cycle.
- `busy_o` and `done_o` are registered outputs, with no combinational path from inputs.
- The operand registers decouple the block from `rs1_i`/`rs2_i`/`op_i`; those inputs may change freely after E0.

## Test plan
- **Reset**: hold `reset_i`=0 for 2 cycles, release -> `busy_o`=0, `done_o`=0, `result_o`=0.
- **Basic MUL**: op=00, rs1=3, rs2=7, start at E0 -> `busy_o`=1 for 5 cycles, then `done_o` pulse with `result_o`=0x0000_0015 in the cycle after E5.
- **High-word variants** (one op each, back-to-back, second start on the `done_o`+1 edge):
  - MULH 0x8000_0000 x 0x8000_0000 -> 0x4000_0000.
  - MULHU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE.
  - MULHSU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFF.
- **Sign edges**:
  - MULH 0xFFFF_FFFF x 0x0000_0001 -> 0xFFFF_FFFF.
  - MULH 0x0000_0000 x 0xFFFF_FFFB -> 0x0000_0000.
  - MUL 0x8000_0000 x 0xFFFF_FFFF -> 0x8000_0000.
- **Busy/kill**:
  - Pulse `start_i` with new operands during STEP cnt=2 -> ignored; the first result is unchanged.
  - Assert `kill_i` at cnt=1 -> IDLE next edge, no `done_o`, `result_o` keeps its previous value.
- **Reset mid-op**: drive `reset_i`=0 during FIX -> no `done_o`, `result_o`=0. A following MULHU 0x0001_0000 x 0x0001_0000 -> 0x0000_0001.

Source files
------------

// File: rtl/mul32_seq_ctrl.sv
// RV32M multiply sequencer: one 16x16 multiplier time-shared over four partial
// products, with sign handling done on magnitudes and a final conditional negate.
module multiplier_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  assign p = a * b;
endmodule

module mul32_seq_ctrl (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic        kill_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);
  typedef enum logic [1:0] {IDLE, STEP, FIX} state_t;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_MULH = 2'b01,
                            OP_MULHSU = 2'b10, OP_MULHU = 2'b11} op_t;

  state_t      state;
  op_t         op;
  logic [1:0]  cnt;
  logic        s1, s2;
  logic [31:0] a, b;
  logic [63:0] acc;

  logic        s1_in, s2_in;
  logic [15:0] ma, mb;
  logic [31:0] pp;
  logic [63:0] addend, p;

  multiplier_16 u_mul (.a(ma), .b(mb), .p(pp));

  always_comb begin
    s1_in = rs1_i[31] & ((op_i == OP_MULH) | (op_i == OP_MULHSU));
    s2_in = rs2_i[31] & (op_i == OP_MULH);
    // cnt[1] selects the a half, cnt[0] the b half
    ma = cnt[1] ? a[31:16] : a[15:0];
    mb = cnt[0] ? b[31:16] : b[15:0];
    addend = '0;
    case (cnt)
      2'd0:       addend = {32'b0, pp};
      2'd1, 2'd2: addend = {16'b0, pp, 16'b0};
      default:    addend = {pp, 32'b0};
    endcase
    p = (s1 ^ s2) ? (~acc + 64'd1) : acc;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state    <= IDLE;
      op       <= OP_MUL;
      cnt      <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      a        <= '0;
      b        <= '0;
      acc      <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !kill_i) begin
            op     <= op_t'(op_i);
            s1     <= s1_in;
            s2     <= s2_in;
            a      <= s1_in ? (~rs1_i + 32'd1) : rs1_i;
            b      <= s2_in ? (~rs2_i + 32'd1) : rs2_i;
            acc    <= '0;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= STEP;
          end
        end
        STEP: begin
          if (kill_i) begin
            cnt    <= '0;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            acc <= acc + addend;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= FIX;
          end
        end
        FIX: begin
          busy_o <= 1'b0;
          state  <= IDLE;
          if (!kill_i) begin
            result_o <= (op == OP_MUL) ? p[31:0] : p[63:32];
            done_o   <= 1'b1;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Directed bench for mul32_seq_ctrl: hand-computed products, cycle-exact busy/done.
module tb_mul32_seq_ctrl;
  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        kill_i = 1'b0;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  int n_cmp = 0;
  int n_err = 0;

  mul32_seq_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .kill_i(kill_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full operation from the accepting edge through the done cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] exp);
    op_i = op; rs1_i = r1; rs2_i = r2; start_i = 1'b1;
    tick();
    start_i = 1'b0; op_i = 2'b00; rs1_i = $urandom; rs2_i = $urandom;
    chk({tag, "_busy0"}, {31'b0, busy_o}, 32'd1);
    chk({tag, "_done0"}, {31'b0, done_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({tag, "_busy"}, {31'b0, busy_o}, 32'd1);
      chk({tag, "_done"}, {31'b0, done_o}, 32'd0);
    end
    tick();
    chk({tag, "_busyfix"}, {31'b0, busy_o}, 32'd0);
    chk({tag, "_donefix"}, {31'b0, done_o}, 32'd1);
    chk({tag, "_result"}, result_o, exp);
  endtask

  initial begin
    // reset held for two edges
    tick(); tick();
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_result", result_o, 32'h0);
    reset_i = 1'b1;
    tick();
    chk("idle_busy", {31'b0, busy_o}, 32'd0);

    run_op("mul_basic", 2'b00, 32'd3, 32'd7, 32'h0000_0015);
    tick();
    chk("mul_basic_pulse", {31'b0, done_o}, 32'd0);

    // back-to-back: each start lands on the edge after the done cycle
    run_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh_neg1", 2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF);
    run_op("mulh_zero", 2'b01, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000);
    run_op("mul_lo", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("mulhu_mix", 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E);
    run_op("mul_mix", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080);
    tick();

    // start while busy at cnt=2 is ignored
    op_i = 2'b00; rs1_i = 32'd5; rs2_i = 32'd6; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick();
    op_i = 2'b11; rs1_i = 32'hFFFF_FFFF; rs2_i = 32'hFFFF_FFFF; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("ign_busy", {31'b0, busy_o}, 32'd1);
    tick(); tick();
    chk("ign_done", {31'b0, done_o}, 32'd1);
    chk("ign_result", result_o, 32'd30);
    tick();
    chk("ign_noreq_done", {31'b0, done_o}, 32'd0);
    chk("ign_noreq_busy", {31'b0, busy_o}, 32'd0);
    tick();
    chk("ign_idle_busy", {31'b0, busy_o}, 32'd0);

    // kill at cnt=1
    op_i = 2'b00; rs1_i = 32'd9; rs2_i = 32'd9; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    chk("kill_busy", {31'b0, busy_o}, 32'd0);
    chk("kill_done", {31'b0, done_o}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("kill_nodone", {31'b0, done_o}, 32'd0);
    end
    chk("kill_result", result_o, 32'd30);

    // kill in FIX beats completion
    op_i = 2'b00; rs1_i = 32'd11; rs2_i = 32'd11; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick(); tick(); tick();
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    chk("killfix_done", {31'b0, done_o}, 32'd0);
    chk("killfix_result", result_o, 32'd30);

    // kill together with start in IDLE: start ignored
    op_i = 2'b00; rs1_i = 32'd2; rs2_i = 32'd2; start_i = 1'b1; kill_i = 1'b1;
    tick();
    start_i = 1'b0; kill_i = 1'b0;
    chk("killstart_busy", {31'b0, busy_o}, 32'd0);
    tick();

    // reset during FIX
    op_i = 2'b01; rs1_i = 32'hFFFF_FFFF; rs2_i = 32'd7; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick(); tick(); tick();
    reset_i = 1'b0;
    tick();
    reset_i = 1'b1;
    chk("rstmid_busy", {31'b0, busy_o}, 32'd0);
    chk("rstmid_done", {31'b0, done_o}, 32'd0);
    chk("rstmid_result", result_o, 32'h0);
    tick();
    chk("rstmid_after_done", {31'b0, done_o}, 32'd0);
    run_op("mulhu_post", 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
